// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator request scheduler.
// The operand check is compiled in with the CALC_OPERAND_CHK_EN macro.
package calc_pkg;

    localparam int CALC_DW = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_EXEC  = 2'd2,
        ST_RESP  = 2'd3
    } calc_state_e;

    localparam logic OPR_ARITH = 1'b0;
    localparam logic OPR_LOGIC = 1'b1;

    localparam logic [1:0] ARITH_ADD  = 2'b00;
    localparam logic [1:0] ARITH_SUB  = 2'b01;
    localparam logic [1:0] LOGIC_EQ   = 2'b00;
    localparam logic [1:0] LOGIC_GT   = 2'b01;
    localparam logic [1:0] LOGIC_LT   = 2'b10;
    localparam logic [1:0] LOGIC_RSVD = 2'b11;

    // True when the datapath would not produce a result for this request.
    function automatic logic calc_op_rejected(input logic dt2_lsb, input logic opr_sel,
                                              input logic [1:0] op);
        logic bad_op_s;
        if (opr_sel == OPR_ARITH) begin
            bad_op_s = op[1];
        end else begin
            bad_op_s = (op == LOGIC_RSVD);
        end
        return (dt2_lsb == 1'b0) || bad_op_s;
    endfunction

endpackage

// File: rtl/calc_rr_arbiter.sv
// Round-robin arbiter: first request at or after the pointer wins, pointer
// moves past the winner only when the grant is actually taken.
module calc_rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic                       upd_en,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
    output logic                       gnt_any
);

    localparam int IW = $clog2(NUM_REQ);

    logic [IW-1:0] ptr_r;
    logic [IW-1:0] cand_s;

    // Wrapping search starting at the pointer.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand_s  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_s  = IW'((int'(ptr_r) + i) % NUM_REQ);
            gnt_idx = (!gnt_any && req[cand_s]) ? cand_s : gnt_idx;
            gnt_any = gnt_any | req[cand_s];
        end
        gnt = gnt_any ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_idx) : '0;
    end

    // Pointer register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            ptr_r <= '0;
        end else if (upd_en && gnt_any) begin
            ptr_r <= IW'((int'(gnt_idx) + 1) % NUM_REQ);
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/calc_req_scheduler.sv
// Shares one calculator datapath between NUM_REQ requesters, one op in flight.
// CALC_OPERAND_CHK_EN enables rejection of requests the datapath cannot serve.
module calc_req_scheduler
    import calc_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DW      = CALC_DW,
    parameter int ALU_LAT = 1
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*DW-1:0]      req_dt1,
    input  logic [NUM_REQ*DW-1:0]      req_dt2,
    input  logic [NUM_REQ-1:0]         req_opr_sel,
    input  logic [NUM_REQ*2-1:0]       req_op,
    output logic [DW-1:0]              alu_dt1,
    output logic [DW-1:0]              alu_dt2,
    output logic                       alu_opr_sel,
    output logic [1:0]                 alu_arith_op,
    output logic [1:0]                 alu_logic_op,
    input  logic [DW:0]                alu_out_a,
    input  logic                       alu_out_l,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [DW:0]                rsp_data,
    output logic                       rsp_err
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(ALU_LAT + 1);

    calc_state_e       state_r;
    calc_state_e       state_s;
    logic [CW-1:0]     cnt_r;
    logic [IW-1:0]     id_r;
    logic [NUM_REQ-1:0] gnt_s;
    logic [IW-1:0]     gnt_idx_s;
    logic              gnt_any_s;
    logic              grant_en_s;
    logic              reject_s;
    logic [DW-1:0]     g_dt1_s;
    logic [DW-1:0]     g_dt2_s;
    logic              g_sel_s;
    logic [1:0]        g_op_s;

    calc_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .Clk     (Clk),
        .Rst     (Rst),
        .req     (req_valid),
        .upd_en  (grant_en_s),
        .gnt     (gnt_s),
        .gnt_idx (gnt_idx_s),
        .gnt_any (gnt_any_s)
    );

    // Grantee field selection and optional rejection.
    always_comb begin
        g_dt1_s = req_dt1[int'(gnt_idx_s)*DW +: DW];
        g_dt2_s = req_dt2[int'(gnt_idx_s)*DW +: DW];
        g_sel_s = req_opr_sel[gnt_idx_s];
        g_op_s  = req_op[int'(gnt_idx_s)*2 +: 2];
`ifdef CALC_OPERAND_CHK_EN
        reject_s = calc_op_rejected(g_dt2_s[0], g_sel_s, g_op_s);
`else
        reject_s = 1'b0;
`endif
    end

    // State register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (gnt_any_s) begin
                    state_s = reject_s ? ST_RESP : ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: state_s = ST_EXEC;
            ST_EXEC: begin
                if (cnt_r == '0) begin
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_EXEC;
                end
            end
            ST_RESP: begin
                if (rsp_valid && rsp_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Accept pulse is same-cycle so a requester sees it while still presenting.
    always_comb begin
        grant_en_s = (state_r == ST_IDLE) && gnt_any_s && !Rst;
        req_ready  = grant_en_s ? gnt_s : '0;
    end

    // Datapath drive, latency counter and response registers.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt_r        <= '0;
            id_r         <= '0;
            alu_dt1      <= '0;
            alu_dt2      <= '0;
            alu_opr_sel  <= 1'b0;
            alu_arith_op <= 2'b00;
            alu_logic_op <= 2'b00;
            rsp_valid    <= 1'b0;
            rsp_id       <= '0;
            rsp_data     <= '0;
            rsp_err      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_en_s && reject_s) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_data  <= '0;
                        rsp_id    <= gnt_idx_s;
                    end else if (grant_en_s) begin
                        id_r        <= gnt_idx_s;
                        alu_dt1     <= g_dt1_s;
                        alu_dt2     <= g_dt2_s;
                        alu_opr_sel <= g_sel_s;
                        if (g_sel_s == OPR_ARITH) begin
                            alu_arith_op <= g_op_s;
                        end else begin
                            alu_logic_op <= g_op_s;
                        end
                    end else begin
                        rsp_valid <= 1'b0;
                    end
                end
                ST_ISSUE: cnt_r <= CW'(ALU_LAT - 1);
                ST_EXEC: begin
                    if (cnt_r == '0) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_id    <= id_r;
                        rsp_data  <= (alu_opr_sel == OPR_ARITH) ? alu_out_a
                                                                 : {{DW{1'b0}}, alu_out_l};
                    end else begin
                        cnt_r <= cnt_r - CW'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end else begin
                        rsp_valid <= 1'b1;
                    end
                end
                default: rsp_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_req_scheduler.sv
// Directed testbench for calc_req_scheduler with a one-cycle registered
// calculator model; expectations follow CALC_OPERAND_CHK_EN when defined.
module tb_calc_req_scheduler;
    import calc_pkg::*;

    localparam int NR = 4;
    localparam int W  = 3;

    logic            Clk = 1'b0;
    logic            Rst;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [NR*W-1:0] req_dt1;
    logic [NR*W-1:0] req_dt2;
    logic [NR-1:0]   req_opr_sel;
    logic [NR*2-1:0] req_op;
    logic [W-1:0]    alu_dt1;
    logic [W-1:0]    alu_dt2;
    logic            alu_opr_sel;
    logic [1:0]      alu_arith_op;
    logic [1:0]      alu_logic_op;
    logic [W:0]      alu_out_a;
    logic            alu_out_l;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [1:0]      rsp_id;
    logic [W:0]      rsp_data;
    logic            rsp_err;

    int checks = 0;
    int errors = 0;
    int cyc;

    calc_req_scheduler #(.NUM_REQ(NR), .DW(W), .ALU_LAT(1)) dut (
        .Clk(Clk), .Rst(Rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dt1(req_dt1), .req_dt2(req_dt2),
        .req_opr_sel(req_opr_sel), .req_op(req_op),
        .alu_dt1(alu_dt1), .alu_dt2(alu_dt2), .alu_opr_sel(alu_opr_sel),
        .alu_arith_op(alu_arith_op), .alu_logic_op(alu_logic_op),
        .alu_out_a(alu_out_a), .alu_out_l(alu_out_l),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    always #5 Clk = ~Clk;

    // Registered calculator datapath, one cycle latency.
    always_ff @(posedge Clk) begin
        case (alu_arith_op)
            ARITH_ADD: alu_out_a <= {1'b0, alu_dt1} + {1'b0, alu_dt2};
            ARITH_SUB: alu_out_a <= {1'b0, alu_dt1} - {1'b0, alu_dt2};
            default:   alu_out_a <= '0;
        endcase
        case (alu_logic_op)
            LOGIC_EQ: alu_out_l <= (alu_dt1 == alu_dt2);
            LOGIC_GT: alu_out_l <= (alu_dt1 > alu_dt2);
            LOGIC_LT: alu_out_l <= (alu_dt1 < alu_dt2);
            default:  alu_out_l <= 1'b0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge Clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [2:0] d1, input logic [2:0] d2,
                           input logic sel, input logic [1:0] op);
        req_dt1[i*W +: W]  = d1;
        req_dt2[i*W +: W]  = d2;
        req_opr_sel[i]     = sel;
        req_op[i*2 +: 2]   = op;
    endtask

    task automatic wait_rsp(input string tag, output int n);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk(tag, rsp_valid, 1);
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        #1;
        while (req_ready === '0 && n < 20) begin
            tick();
            n++;
        end
        chk(tag, (n < 20) ? 1 : 0, 1);
    endtask

    task automatic chk_reset;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_alu_dt1", alu_dt1, 0);
        chk("rst_alu_dt2", alu_dt2, 0);
        chk("rst_alu_opr_sel", alu_opr_sel, 0);
        chk("rst_alu_arith_op", alu_arith_op, 0);
        chk("rst_alu_logic_op", alu_logic_op, 0);
        chk("rst_req_ready", req_ready, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        Rst = 1'b1;
        req_valid = '0; req_dt1 = '0; req_dt2 = '0; req_opr_sel = '0; req_op = '0;
        rsp_ready = 1'b0;
        tick();
        tick();
        chk_reset();
        Rst = 1'b0;
        tick();

        // 1: single arithmetic add from requester 0
        set_req(0, 3'd3, 3'd1, OPR_ARITH, ARITH_ADD);
        req_valid = 4'b0001;
        #1;
        chk("t1_ready", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        #1;
        chk("t1_ready_drop", req_ready, 0);
        chk("t1_alu_dt1", alu_dt1, 3);
        chk("t1_alu_dt2", alu_dt2, 1);
        wait_rsp("t1_valid", cyc);
        chk("t1_latency", cyc, 2);
        chk("t1_id", rsp_id, 0);
        chk("t1_data", rsp_data, 4);
        chk("t1_err", rsp_err, 0);
        rsp_ready = 1'b1;
        tick();
        chk("t1_accept", rsp_valid, 0);
        rsp_ready = 1'b0;

        // 2: all requesters held valid, round-robin from 0
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        for (int i = 0; i < NR; i++) set_req(i, 3'(i), 3'd1, OPR_ARITH, ARITH_ADD);
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_ready("t2_ready_seen");
            chk("t2_grant", req_ready, 32'd1 << (k % NR));
            wait_rsp("t2_valid", cyc);
            chk("t2_id", rsp_id, k % NR);
            chk("t2_data", rsp_data, (k % NR) + 1);
        end
        req_valid = '0;
        tick();
        chk("t2_accept", rsp_valid, 0);
        rsp_ready = 1'b0;

        // 3: logical gt from requester 2 with a stalled response
        set_req(2, 3'd5, 3'd3, OPR_LOGIC, LOGIC_GT);
        req_valid = 4'b0100;
        #1;
        chk("t3_ready", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        wait_rsp("t3_valid", cyc);
        chk("t3_data", rsp_data, 4'b0001);
        chk("t3_id", rsp_id, 2);
        req_valid = 4'b1111;
        #1;
        chk("t3_stall_ready", req_ready, 0);
        for (int s = 0; s < 5; s++) begin
            tick();
            chk("t3_stall_valid", rsp_valid, 1);
            chk("t3_stall_data", rsp_data, 1);
            chk("t3_stall_id", rsp_id, 2);
            chk("t3_stall_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        req_valid = '0;
        tick();
        chk("t3_accept", rsp_valid, 0);
        rsp_ready = 1'b0;

        // 4: reset during EXEC, next search starts at requester 0
        set_req(0, 3'd2, 3'd3, OPR_ARITH, ARITH_SUB);
        req_valid = 4'b0100;
        #1;
        chk("t4_ready", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        tick();
        Rst = 1'b1;
        tick();
        chk_reset();
        Rst = 1'b0;
        req_valid = 4'b1001;
        #1;
        chk("t4_ptr_zero", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        wait_rsp("t4_valid", cyc);
        chk("t4_data", rsp_data, 4'b1111);
        chk("t4_id", rsp_id, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // 5: even dt2 operand
        set_req(1, 3'd1, 3'd2, OPR_ARITH, ARITH_ADD);
        req_valid = 4'b0010;
        #1;
        chk("t5_ready", req_ready, 4'b0010);
        tick();
        req_valid = '0;
        wait_rsp("t5_valid", cyc);
        chk("t5_id", rsp_id, 1);
`ifdef CALC_OPERAND_CHK_EN
        chk("t5_err", rsp_err, 1);
        chk("t5_data", rsp_data, 0);
        chk("t5_alu_dt1", alu_dt1, 2);
        chk("t5_alu_dt2", alu_dt2, 3);
`else
        chk("t5_err", rsp_err, 0);
        chk("t5_data", rsp_data, 3);
        chk("t5_alu_dt1", alu_dt1, 1);
        chk("t5_alu_dt2", alu_dt2, 2);
`endif
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // 6: req1 pulses only while a response is pending
        set_req(3, 3'd7, 3'd1, OPR_ARITH, ARITH_ADD);
        req_valid = 4'b1000;
        #1;
        chk("t6_ready", req_ready, 4'b1000);
        tick();
        req_valid = '0;
        wait_rsp("t6_valid", cyc);
        chk("t6_data", rsp_data, 4'b1000);
        chk("t6_id", rsp_id, 3);
        req_valid = 4'b0010;
        #1;
        chk("t6_pulse_ready", req_ready, 0);
        tick();
        req_valid = '0;
        #1;
        chk("t6_after_pulse", req_ready, 0);
        rsp_ready = 1'b1;
        tick();
        chk("t6_accept", rsp_valid, 0);
        chk("t6_idle_ready", req_ready, 0);
        rsp_ready = 1'b0;
        tick();
        chk("t6_no_grant", req_ready, 0);
        chk("t6_no_rsp", rsp_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
